// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8-bit UART transmitter with optional parity and a valid/ready byte input
module uart_tx_frame #(
    parameter int N       = 8,
    parameter int PSCALER = 1,
    parameter int DIV     = 10
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t     state;
    logic [7:0] data;
    logic       par_en;
    logic       par_odd;
    logic [N-1:0]  psc;
    logic [TW-1:0] tcnt;
    logic [2:0] idx;
    logic       tick;
    logic       bit_end;
    assign tick    = psc == N'(PSCALER - 1);
    assign bit_end = tick && tcnt == TW'(DIV - 1);
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            data    <= '0;
            par_en  <= 1'b0;
            par_odd <= 1'b0;
            psc     <= '0;
            tcnt    <= '0;
            idx     <= '0;
            tx_o    <= 1'b1;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state != IDLE) begin
                psc <= tick ? '0 : psc + 1'b1;
                if (tick) tcnt <= bit_end ? '0 : tcnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        data    <= data_i;
                        par_en  <= parity_en_i;
                        par_odd <= parity_odd_i;
                        psc     <= '0;
                        tcnt    <= '0;
                        idx     <= '0;
                        tx_o    <= 1'b0;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                        state   <= START;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_o  <= data[0];
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        // idx saturates at 7 so a ninth data bit can never be emitted
                        if (idx != 3'd7) begin
                            idx  <= idx + 3'd1;
                            tx_o <= data[idx + 3'd1];
                        end else if (par_en) begin
                            tx_o  <= par_odd ? ~^data : ^data;
                            state <= PARITY;
                        end else begin
                            tx_o  <= 1'b1;
                            state <= STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_o  <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        done_o  <= 1'b1;
                        busy_o  <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    tx_o    <= 1'b1;
                    busy_o  <= 1'b0;
                    ready_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
